// File: rtl/chseq_pkg.sv
// Shared types and default sizes for the channel sequencer/mux.
package chseq_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SERIAL = 1'b1
  } chseq_mode_e;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } chseq_state_e;

  localparam int CHSEQ_WIDTH  = 8;
  localparam int CHSEQ_NUM_CH = 3;

endpackage

// File: rtl/chan_mux.sv
// Combinational NUM_CH:1 channel mux; out-of-range select yields zero,
// matching the legacy fixed-width pixel muxes it replaces.
module chan_mux #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 3,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH*WIDTH-1:0] i_word,
  input  logic [SEL_W-1:0]        i_sel,
  output logic [WIDTH-1:0]        o_data
);

  // Pick channel i_sel, zero when no channel matches.
  always_comb begin
    o_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (i_sel == SEL_W'(k)) o_data = i_word[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/chan_seq_mux.sv
// Handshaked multi-channel pixel mux: captures one NUM_CH-channel word and
// emits either the selected channel (direct) or every channel in order
// (serialise). Optional macro CHSEQ_SEL_ERR_EN adds a sticky sel_err flag
// raised by a direct-mode accept with an out-of-range select.
module chan_seq_mux
  import chseq_pkg::*;
#(
  parameter int WIDTH  = CHSEQ_WIDTH,
  parameter int NUM_CH = CHSEQ_NUM_CH,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
`ifdef CHSEQ_SEL_ERR_EN
  output logic                    sel_err,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_last
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  chseq_state_e              r_state;
  chseq_mode_e               r_mode;
  logic [NUM_CH*WIDTH-1:0]   r_hold;
  logic                      r_out_valid;
  logic [WIDTH-1:0]          r_out_data;
  logic [SEL_W-1:0]          r_out_ch;
  logic                      r_out_last;

  chseq_state_e              w_state_nxt;
  logic                      w_out_valid_nxt;
  logic [SEL_W-1:0]          w_out_ch_nxt;
  logic                      w_out_last_nxt;
  logic                      w_load_data;
  logic [NUM_CH*WIDTH-1:0]   w_mux_word;
  logic [WIDTH-1:0]          w_mux_data;
  logic                      w_beat_take;
  logic                      w_accept;

  assign w_beat_take = r_out_valid && out_ready;
  // A pixel can enter while the previous pixel's final beat leaves: no bubble.
  assign in_ready    = (r_state == ST_IDLE) || (w_beat_take && r_out_last);
  assign w_accept    = in_valid && in_ready;

  // The first beat is muxed from the incoming word so it is ready one cycle
  // after accept; later beats come from the holding register.
  chan_mux #(
    .WIDTH  (WIDTH),
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_chan_mux (
    .i_word (w_mux_word),
    .i_sel  (w_out_ch_nxt),
    .o_data (w_mux_data)
  );

  // Next state and next output beat.
  always_comb begin
    w_state_nxt     = r_state;
    w_out_valid_nxt = r_out_valid;
    w_out_ch_nxt    = r_out_ch;
    w_out_last_nxt  = r_out_last;
    w_load_data     = 1'b0;
    w_mux_word      = r_hold;
    if (w_accept) begin
      w_state_nxt     = ST_EMIT;
      w_out_valid_nxt = 1'b1;
      w_load_data     = 1'b1;
      w_mux_word      = in_data;
      if (mode == MODE_SERIAL) begin
        w_out_ch_nxt   = '0;
        w_out_last_nxt = 1'b0;
      end else begin
        w_out_ch_nxt   = sel;
        w_out_last_nxt = 1'b1;
      end
    end else if (w_beat_take) begin
      if (r_out_last) begin
        w_state_nxt     = ST_IDLE;
        w_out_valid_nxt = 1'b0;
        if (r_mode == MODE_SERIAL) w_out_ch_nxt = '0;
      end else begin
        w_out_ch_nxt   = r_out_ch + SEL_W'(1);
        w_out_last_nxt = (w_out_ch_nxt == LAST_CH);
        w_load_data    = 1'b1;
      end
    end
  end

  // State, mode and registered output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_DIRECT;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_ch    <= w_out_ch_nxt;
      r_out_last  <= w_out_last_nxt;
      if (w_accept)    r_mode     <= chseq_mode_e'(mode);
      if (w_load_data) r_out_data <= w_mux_data;
    end
  end

  // Holding register for the captured pixel word.
  always_ff @(posedge clk) begin
    if (w_accept) r_hold <= in_data;
  end

`ifdef CHSEQ_SEL_ERR_EN
  logic r_sel_err;
  logic w_sel_oob;

  assign w_sel_oob = (int'(sel) >= NUM_CH);

  // Sticky flag for any direct-mode accept with an out-of-range select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sel_err <= 1'b0;
    else if (w_accept && (mode == MODE_DIRECT) && w_sel_oob) r_sel_err <= 1'b1;
  end

  assign sel_err = r_sel_err;
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_last  = r_out_last;

endmodule
